// File: rtl/rx_decap_if.sv
// RX decapsulator bus: decoder input, FIFO writes,
// PAUSE handshake and drop counter.
interface rx_decap_if;
  logic        rx_dvld;
  logic        rx_sof;
  logic        rx_eof;
  logic [63:0] rx_data;
  logic [2:0]  rx_lbytes;
  logic        rx_err;
  logic        rxfifo_full;
  logic        rxfifo_afull;
  logic        rxfifo_wr_en;
  logic [63:0] rxfifo_din;
  logic        rxstat_full;
  logic        rxstat_wr_en;
  logic [31:0] rxstat_din;
  logic        rx_pause;
  logic [15:0] rx_pvalue;
  logic        rx_pack;
  logic [15:0] drop_cnt;

  modport master (
    output rx_dvld, rx_sof, rx_eof, rx_data,
    output rx_lbytes, rx_err,
    output rxfifo_full, rxfifo_afull,
    output rxstat_full, rx_pack,
    input  rxfifo_wr_en, rxfifo_din,
    input  rxstat_wr_en, rxstat_din,
    input  rx_pause, rx_pvalue, drop_cnt
  );

  modport slave (
    input  rx_dvld, rx_sof, rx_eof, rx_data,
    input  rx_lbytes, rx_err,
    input  rxfifo_full, rxfifo_afull,
    input  rxstat_full, rx_pack,
    output rxfifo_wr_en, rxfifo_din,
    output rxstat_wr_en, rxstat_din,
    output rx_pause, rx_pvalue, drop_cnt
  );
endinterface

// File: rtl/rx_decap.sv
// RX decapsulator: frame words into data/status
// FIFOs, 802.3x PAUSE detection toward tx_encap.
module rx_decap #(
  parameter logic [15:0] MAX_LEN   = 16'd9600,
  parameter bit          PAUSE_FWD = 1'b0
) (
  input logic       clk,
  input logic       rst_,
  rx_decap_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, HDR, PAUSE, FWD, DROP, STAT
  } state_t;

  localparam logic [47:0] PAUSE_DA =
    48'h0100_00C2_8001;
  localparam logic [31:0] PAUSE_ET =
    32'h0100_0888;

  state_t      state;
  state_t      state_n;

  logic [63:0] hold;
  logic        hold_v;
  logic        hold_ovr;
  logic [15:0] len;
  logic        err;
  logic        trunc;
  logic        ovr;
  logic        disc;
  logic        is_p;
  logic        drop_after;
  logic [1:0]  wcnt;
  logic [15:0] pv_cap;
  logic [15:0] pvalue;
  logic        pause;
  logic [15:0] drops;

  logic        dv;
  logic        sof;
  logic        eof;
  logic        start;
  logic        take;
  logic        close;
  logic        drop;
  logic        classify;
  logic        pause_hit;
  logic        wr_cand;
  logic        wr_ok;
  logic        wr_en;
  logic        full_hit;
  logic        pause_w;
  logic [3:0]  bytes;
  logic [15:0] len_base;
  logic [16:0] len_sum;
  logic [15:0] len_n;
  logic        over;
  logic [15:0] pv_new;

  assign dv  = bus.rx_dvld;
  assign sof = bus.rx_sof;
  assign eof = bus.rx_eof;

  assign bytes =
    (eof && bus.rx_lbytes != 3'd0) ?
    {1'b0, bus.rx_lbytes} : 4'd8;

  assign len_base = start ? 16'd0 : len;
  assign len_sum  = {1'b0, len_base} +
                    {13'd0, bytes};
  assign len_n    = len_sum[16] ?
                    16'hFFFF : len_sum[15:0];
  assign over     = len_n > MAX_LEN;

  assign pause_w =
    (hold[47:0] == PAUSE_DA) &&
    (bus.rx_data[63:32] == PAUSE_ET);

  assign pv_new = (wcnt == 2'd2) ?
    {bus.rx_data[7:0], bus.rx_data[15:8]} :
    pv_cap;

  // Frame sequencing and per-cycle actions
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    take      = 1'b0;
    close     = 1'b0;
    drop      = 1'b0;
    classify  = 1'b0;
    pause_hit = 1'b0;
    wr_cand   = 1'b0;
    unique case (state)
      IDLE: begin
        if (dv && sof) begin
          if (bus.rxfifo_afull ||
              bus.rxstat_full) begin
            drop    = 1'b1;
            state_n = eof ? IDLE : DROP;
          end else begin
            start   = 1'b1;
            state_n = eof ? STAT : HDR;
          end
        end
      end
      HDR: begin
        if (dv && sof) begin
          close   = 1'b1;
          drop    = 1'b1;
          state_n = STAT;
        end else if (dv) begin
          take     = 1'b1;
          classify = 1'b1;
          wr_cand  = !pause_w || PAUSE_FWD;
          if (eof)
            state_n = (pause_w && !PAUSE_FWD) ?
                      IDLE : STAT;
          else
            state_n = pause_w ? PAUSE : FWD;
        end
      end
      PAUSE, FWD: begin
        if (dv && sof) begin
          close = 1'b1;
          drop  = 1'b1;
          if (state == FWD || PAUSE_FWD)
            state_n = STAT;
          else
            state_n = eof ? IDLE : DROP;
        end else if (dv) begin
          take    = 1'b1;
          wr_cand = (state == FWD) || PAUSE_FWD;
          if (eof) begin
            pause_hit = (state == PAUSE) &&
                        !bus.rx_err &&
                        (wcnt >= 2'd2);
            state_n = ((state == FWD) ||
                       PAUSE_FWD) ? STAT : IDLE;
          end
        end
      end
      DROP: begin
        if (dv && sof) begin
          drop    = 1'b1;
          state_n = eof ? IDLE : DROP;
        end else if (dv && eof) begin
          state_n = IDLE;
        end
      end
      STAT: begin
        wr_cand = 1'b1;
        state_n = drop_after ? DROP : IDLE;
        if (dv && sof) begin
          drop    = 1'b1;
          state_n = eof ? IDLE : DROP;
        end else if (dv && eof) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The held word is written one word late; a full
  // FIFO discards it and everything after it.
  assign wr_ok    = wr_cand && hold_v &&
                    !hold_ovr && !disc;
  assign wr_en    = wr_ok && !bus.rxfifo_full;
  assign full_hit = wr_ok && bus.rxfifo_full;

  // State register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_n;
  end

  // Hold register and per-frame status fields
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      hold       <= '0;
      hold_v     <= 1'b0;
      hold_ovr   <= 1'b0;
      len        <= '0;
      err        <= 1'b0;
      trunc      <= 1'b0;
      ovr        <= 1'b0;
      disc       <= 1'b0;
      is_p       <= 1'b0;
      drop_after <= 1'b0;
      wcnt       <= '0;
      pv_cap     <= '0;
    end else if (start) begin
      hold       <= bus.rx_data;
      hold_v     <= 1'b1;
      hold_ovr   <= over;
      len        <= len_n;
      err        <= eof & bus.rx_err;
      trunc      <= over;
      ovr        <= over;
      disc       <= 1'b0;
      is_p       <= 1'b0;
      drop_after <= 1'b0;
      wcnt       <= 2'd1;
    end else begin
      if (full_hit) begin
        disc  <= 1'b1;
        trunc <= 1'b1;
      end
      if (take) begin
        hold     <= bus.rx_data;
        hold_ovr <= over;
        len      <= len_n;
        if (over) begin
          ovr   <= 1'b1;
          trunc <= 1'b1;
        end
        if (eof) err <= bus.rx_err;
        if (wcnt != 2'd3) wcnt <= wcnt + 2'd1;
        if (state == PAUSE && wcnt == 2'd2)
          pv_cap <= {bus.rx_data[7:0],
                     bus.rx_data[15:8]};
      end
      if (classify) is_p <= pause_w;
      if (close) begin
        trunc      <= 1'b1;
        drop_after <= !eof;
      end
      if (state_n == IDLE || state_n == DROP)
        hold_v <= 1'b0;
    end
  end

  // PAUSE request held until tx_encap acknowledges
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pause  <= 1'b0;
      pvalue <= '0;
    end else if (pause_hit) begin
      pause  <= 1'b1;
      pvalue <= pv_new;
    end else if (pause && bus.rx_pack) begin
      pause  <= 1'b0;
    end
  end

  // Saturating count of frames dropped at sof
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      drops <= '0;
    else if (drop && drops != 16'hFFFF)
      drops <= drops + 16'd1;
  end

  assign bus.rxfifo_wr_en = wr_en;
  assign bus.rxfifo_din   = wr_en ? hold : '0;
  assign bus.rxstat_wr_en = (state == STAT);
  assign bus.rxstat_din   = (state == STAT) ?
    {12'h0, is_p, ovr, trunc | full_hit,
     err, len} : '0;
  assign bus.rx_pause     = pause;
  assign bus.rx_pvalue    = pvalue;
  assign bus.drop_cnt     = drops;

endmodule
